// File: rtl/obj_gfx_fetch.sv
// Object graphics fetch: takes the object character address each slice, reads three
// bitplanes from graphics ROM over req/ack, and shifts them out as 3-bit QBUS pixels.
module obj_gfx_fetch #(
  parameter int unsigned ROM_AW = 13,
  parameter int unsigned MISS_W = 8
) (
  input  logic              clkm_48MHZ,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              slice_ld,
  input  logic [12:0]       OBJ_CHA,
  input  logic              OBJ_CINV,
  input  logic              INRANG,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [23:0]       rom_data,
  output logic [2:0]        QBUS,
  output logic              busy,
  output logic [MISS_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STALE} state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [ROM_AW-1:0]   nxt_cha_q, nxt_cha_d;
  logic                nxt_cinv_q, nxt_cinv_d;
  logic                nxt_inrang_q, nxt_inrang_d;
  logic [23:0]         stage_q, stage_d;
  logic                stage_valid_q, stage_valid_d;
  logic [23:0]         sh_q, sh_d;
  logic                sh_cinv_q, sh_cinv_d;
  logic [2:0]          qbus_q, qbus_d;
  logic                req_q, req_d;
  logic [ROM_AW-1:0]   addr_q, addr_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  logic b, ack, bypass;

  function automatic logic [23:0] shift_planes(input logic [23:0] s, input logic lsb_first);
    if (lsb_first) return {1'b0, s[23:17], 1'b0, s[15:9], 1'b0, s[7:1]};
    else           return {s[22:16], 1'b0, s[14:8], 1'b0, s[6:0], 1'b0};
  endfunction

  function automatic logic [2:0] pixel_of(input logic [23:0] s, input logic lsb_first);
    if (lsb_first) return {s[16], s[8], s[0]};
    else           return {s[23], s[15], s[7]};
  endfunction

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    nxt_cha_d     = nxt_cha_q;
    nxt_cinv_d    = nxt_cinv_q;
    nxt_inrang_d  = nxt_inrang_q;
    stage_d       = stage_q;
    stage_valid_d = stage_valid_q;
    sh_d          = sh_q;
    sh_cinv_d     = sh_cinv_q;
    qbus_d        = qbus_q;
    req_d         = req_q;
    addr_d        = addr_q;
    miss_d        = miss_q;

    b      = pix_ce & slice_ld;
    ack    = rom_ack & req_q;
    bypass = b & ack & (state_q == S_REQ);

    if (b) begin
      nxt_cha_d     = OBJ_CHA[ROM_AW-1:0];
      nxt_cinv_d    = OBJ_CINV;
      nxt_inrang_d  = INRANG;
      stage_valid_d = 1'b0;
      sh_cinv_d     = nxt_cinv_q;
      if (bypass)             sh_d = rom_data;
      else if (stage_valid_q) sh_d = stage_q;
      else                    sh_d = '0;
      if (nxt_inrang_q && !stage_valid_q && !bypass && (miss_q != '1))
        miss_d = miss_q + MISS_W'(1);
    end else if (pix_ce) begin
      sh_d = shift_planes(sh_q, sh_cinv_q);
    end
    if (pix_ce) qbus_d = pixel_of(sh_d, sh_cinv_d);

    // A request whose slice boundary has passed is always completed, never aborted;
    // the newest slice waits in nxt_* with pend set and is issued from IDLE.
    case (state_q)
      S_IDLE: begin
        if (b) begin
          pend_d = 1'b0;
          if (INRANG) begin
            req_d   = 1'b1;
            addr_d  = OBJ_CHA[ROM_AW-1:0];
            state_d = S_REQ;
          end
        end else if (pend_q) begin
          pend_d  = 1'b0;
          req_d   = 1'b1;
          addr_d  = nxt_cha_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          if (b) begin
            pend_d = INRANG;
          end else begin
            stage_d       = rom_data;
            stage_valid_d = 1'b1;
          end
        end else if (b) begin
          pend_d  = INRANG;
          state_d = S_STALE;
        end
      end
      S_STALE: begin
        if (b) pend_d = INRANG;
        if (ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkm_48MHZ or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pend_q        <= 1'b0;
      nxt_cha_q     <= '0;
      nxt_cinv_q    <= 1'b0;
      nxt_inrang_q  <= 1'b0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      sh_q          <= '0;
      sh_cinv_q     <= 1'b0;
      qbus_q        <= '0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      miss_q        <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      nxt_cha_q     <= nxt_cha_d;
      nxt_cinv_q    <= nxt_cinv_d;
      nxt_inrang_q  <= nxt_inrang_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      sh_q          <= sh_d;
      sh_cinv_q     <= sh_cinv_d;
      qbus_q        <= qbus_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      miss_q        <= miss_d;
    end
  end

  assign rom_addr = addr_q;
  assign rom_req  = req_q;
  assign busy     = req_q;
  assign QBUS     = qbus_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_obj_gfx_fetch.sv
// Directed bench for obj_gfx_fetch: slice timing, ROM handshake, misses and saturation.
module tb_obj_gfx_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        slice_ld = 1'b0;
  logic [12:0] OBJ_CHA = '0;
  logic        OBJ_CINV = 1'b0;
  logic        INRANG = 1'b0;
  logic [12:0] rom_addr;
  logic        rom_req;
  logic        rom_ack = 1'b0;
  logic [23:0] rom_data = '0;
  logic [2:0]  QBUS;
  logic        busy;
  logic [7:0]  miss_cnt;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   req_age  = 0;
  int   ack_dly  = 2;
  logic ack_en   = 1'b0;
  logic [23:0] rom_img = '0;
  logic pce_edge = 1'b0;
  logic saw_req  = 1'b0;

  obj_gfx_fetch #(.ROM_AW(13), .MISS_W(8)) dut (
    .clkm_48MHZ(clk), .reset(reset), .pix_ce(pix_ce), .slice_ld(slice_ld),
    .OBJ_CHA(OBJ_CHA), .OBJ_CINV(OBJ_CINV), .INRANG(INRANG),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
    .QBUS(QBUS), .busy(busy), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs held across the edge, then next-cycle timing and ROM responder.
  task automatic clk1();
    pce_edge = pix_ce;
    @(posedge clk);
    #1;
    cyc++;
    pix_ce   = ((cyc % 8) == 7);
    slice_ld = ((cyc % 64) >= 60);
    rom_ack  = 1'b0;
    saw_req  = saw_req | rom_req;
    if (rom_req && ack_en) begin
      if (req_age == ack_dly) begin
        rom_ack  = 1'b1;
        rom_data = rom_img;
        req_age  = 0;
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
    end
  endtask

  task automatic run_until_b_next();
    int n = 0;
    while (!(pix_ce && slice_ld) && n < 200) begin
      clk1();
      n++;
    end
    if (!(pix_ce && slice_ld)) begin
      n_fail++;
      $error("FAIL b_wait: observed timeout expected slice boundary");
    end
  endtask

  task automatic run_to_b();
    run_until_b_next();
    clk1();
  endtask

  task automatic run_to_pce();
    int n = 0;
    do begin
      clk1();
      n++;
    end while (!pce_edge && n < 20);
    if (!pce_edge) begin
      n_fail++;
      $error("FAIL pce_wait: observed timeout expected pixel enable");
    end
  endtask

  // Expected pixels packed {px0, px1, ..., px7}, 3 bits each.
  task automatic check_slice(input string tag, input logic [23:0] exp);
    logic [23:0] e;
    e = exp;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) run_to_pce();
      chk($sformatf("%s_px%0d", tag, i), 32'(QBUS), 32'(e[23-3*i -: 3]));
    end
  endtask

  initial begin
    repeat (4) clk1();
    chk("rst_qbus", 32'(QBUS), 0);
    chk("rst_req", 32'(rom_req), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_miss", 32'(miss_cnt), 0);
    reset = 1'b0;

    // Normal fetch, MSB-first then LSB-first
    OBJ_CHA = 13'h0123; OBJ_CINV = 1'b0; INRANG = 1'b1;
    rom_img = 24'hF00FAA; ack_en = 1'b1; ack_dly = 2;
    run_to_b();
    chk("t1_req", 32'(rom_req), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_addr", 32'(rom_addr), 32'h0123);
    repeat (4) clk1();
    chk("t1_req_drop", 32'(rom_req), 0);
    chk("t1_addr_hold", 32'(rom_addr), 32'h0123);
    OBJ_CINV = 1'b1;
    run_to_b();
    check_slice("t1", 24'hB2C69A);
    chk("t1_miss", 32'(miss_cnt), 0);
    INRANG = 1'b0;
    run_to_b();
    chk("t3_no_req", 32'(rom_req), 0);
    saw_req = 1'b0;
    check_slice("t2", 24'h4D3965);

    // Out of range: no fetch, transparent slice
    run_to_b();
    check_slice("t3", 24'h000000);
    chk("t3_saw_req", 32'(saw_req), 0);
    chk("t3_miss", 32'(miss_cnt), 0);

    // Late ack: slice misses, stale data dropped, pending request follows
    OBJ_CHA = 13'h0456; OBJ_CINV = 1'b0; INRANG = 1'b1; ack_en = 1'b0;
    run_to_b();
    chk("t4_req", 32'(rom_req), 1);
    chk("t4_addr0", 32'(rom_addr), 32'h0456);
    OBJ_CHA = 13'h0789;
    run_to_b();
    chk("t4_miss", 32'(miss_cnt), 1);
    chk("t4_stale_addr", 32'(rom_addr), 32'h0456);
    chk("t4_stale_req", 32'(rom_req), 1);
    chk("t4_px0", 32'(QBUS), 0);
    repeat (9) clk1();
    rom_ack = 1'b1; rom_data = 24'hFFFFFF;
    clk1();
    chk("t4_stale_drop", 32'(rom_req), 0);
    clk1();
    chk("t4_pend_req", 32'(rom_req), 1);
    chk("t4_pend_addr", 32'(rom_addr), 32'h0789);
    rom_ack = 1'b1; rom_data = 24'h3C0FF0;
    clk1();
    chk("t4_pend_drop", 32'(rom_req), 0);
    chk("t4_px_late", 32'(QBUS), 0);
    INRANG = 1'b0;
    run_to_b();
    check_slice("t4", 24'h26DD92);
    chk("t4_miss_hold", 32'(miss_cnt), 1);

    // Ack on the boundary cycle goes straight to the shifters
    OBJ_CHA = 13'h0ABC; INRANG = 1'b1;
    run_to_b();
    chk("t5_req", 32'(rom_req), 1);
    chk("t5_addr", 32'(rom_addr), 32'h0ABC);
    OBJ_CHA = 13'h0111;
    run_until_b_next();
    rom_ack = 1'b1; rom_data = 24'hFF0000;
    clk1();
    chk("t5_drop", 32'(rom_req), 0);
    chk("t5_miss", 32'(miss_cnt), 1);
    clk1();
    chk("t5_reissue_req", 32'(rom_req), 1);
    chk("t5_reissue_addr", 32'(rom_addr), 32'h0111);
    check_slice("t5", 24'h924924);

    // Asynchronous reset with a request outstanding
    chk("t6_pre_req", 32'(rom_req), 1);
    reset = 1'b1;
    #2;
    chk("t6_req", 32'(rom_req), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_qbus", 32'(QBUS), 0);
    chk("t6_miss", 32'(miss_cnt), 0);
    chk("t6_addr", 32'(rom_addr), 0);
    rom_ack = 1'b1; rom_data = 24'hFFFFFF;
    clk1();
    rom_ack = 1'b1;
    clk1();
    reset = 1'b0;
    INRANG = 1'b0;
    rom_ack = 1'b1;
    clk1();
    chk("t6_ack_ignored", 32'(rom_req), 0);
    run_to_b();
    chk("t6_no_req", 32'(rom_req), 0);
    check_slice("t6", 24'h000000);

    // Saturating miss counter
    OBJ_CHA = 13'h1FFF; INRANG = 1'b1;
    run_to_b();
    chk("t7_addr", 32'(rom_addr), 32'h1FFF);
    repeat (254) run_to_b();
    chk("t7_miss254", 32'(miss_cnt), 254);
    run_to_b();
    chk("t7_miss255", 32'(miss_cnt), 255);
    repeat (45) run_to_b();
    chk("t7_sat", 32'(miss_cnt), 255);
    chk("t7_req_held", 32'(rom_req), 1);
    chk("t7_addr_held", 32'(rom_addr), 32'h1FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/obj_gfx_fetch.md
Name: obj_gfx_fetch

Overview:
- Responder side of the object character-address interface.
- Each 8-pixel slice it accepts the object character address (OBJ_CHA) and attributes produced by the object bus.
- It fetches three bitplane bytes from object graphics ROM over a req/ack handshake, then serialises them into the 3-bit QBUS pixel stream that the object bus writes into its line buffers.
- Sits between the object bus and the ROM/SDRAM arbiter, one slice of pipeline latency.

Parameters:
- ROM_AW, 13, width of graphics ROM address (bit 12 is the sync/bank bit of OBJ_CHA).
- MISS_W, 8, width of saturating late-fetch counter.

Ports:
- clkm_48MHZ  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_ce  in  1  6 MHz pixel enable, one clkm_48MHZ cycle in 8
- slice_ld  in  1  slice boundary; qualified only when pix_ce=1 (last pixel of slice)
- OBJ_CHA  in  13  object character address for the next slice
- OBJ_CINV  in  1  horizontal invert for the next slice
- INRANG  in  1  1 = object in vertical range; 0 = slice transparent, no fetch
- rom_addr  out  ROM_AW  ROM address, stable while rom_req=1
- rom_req  out  1  request, held high until rom_ack
- rom_ack  in  1  one-cycle acknowledge; rom_data valid in the same cycle
- rom_data  in  24  {plane2[7:0], plane1[7:0], plane0[7:0]}
- QBUS  out  3  current pixel {p2,p1,p0}; 0 = transparent
- busy  out  1  request outstanding
- miss_cnt  out  MISS_W  saturating count of slices with no data in time

Behaviour:
- Reset: QBUS=0, rom_req=0, rom_addr=0, busy=0, miss_cnt=0, all shift and staging registers 0, FSM=IDLE, pending=0, stage_valid=0.
- Boundary event B = pix_ce & slice_ld.
- At B:
  - Capture {OBJ_CHA, OBJ_CINV, INRANG} into the next-slice register.
  - Move the staging register into the shifters: data if stage_valid=1, else zeros.
  - Latch the staging cinv into the shifter direction.
  - Clear stage_valid.
- Miss: at B, if the previous slice had INRANG=1 and stage_valid=0, miss_cnt increments, saturating at all-ones.
- Shifting:
  - On each pix_ce that is not B, shift all three planes by one.
  - cinv=0: MSB first, output bit 7. cinv=1: LSB first, output bit 0.
  - Vacated bits fill with 0.
  - QBUS is registered and updates on pix_ce, giving the shifter output bit for the current pixel.
- Latency: address captured at boundary N appears as pixels 0..7 on QBUS during slice N+1.
- FSM states IDLE, REQ, STALE:
  - IDLE: the cycle after B with INRANG=1, drive rom_addr=OBJ_CHA[ROM_AW-1:0] and rom_req=1, go to REQ. INRANG=0 issues no request and stays in IDLE.
  - REQ: on rom_ack, write rom_data to staging, set stage_valid=1, drop rom_req the same edge, go to IDLE. If B occurs before ack, the in-flight data is stale: go to STALE, set pending=1 with the new address (if INRANG=1).
  - STALE: keep rom_req high with the old address (never abort a handshake). On ack, discard the data and drop rom_req. If pending=1, issue the pending request next cycle (go to REQ); otherwise go to IDLE.
  - Further B while in STALE: overwrite pending with the newest slice; count the miss.
- busy = rom_req.
- rom_addr changes only when rom_req=0 or on the cycle a new request is issued.
- Ack and B in the same cycle: the ack counts as in time. The data goes directly to the shifters (bypass), stage_valid stays 0, and no miss is counted.
- rom_ack while rom_req=0: ignored.
- Reset mid-request: rom_req drops immediately (asynchronous); a later ack is ignored.

Test Plan:
- INRANG=1, OBJ_CHA=0x0123, OBJ_CINV=0, ack after 3 cycles with rom_data=0xF0_0F_AA:
  - rom_addr=0x0123;
  - next slice QBUS = 5,4,5,4,3,2,3,2;
  - miss_cnt=0.
- Same data, OBJ_CINV=1 -> QBUS = 2,3,2,3,4,5,4,5.
- INRANG=0 -> rom_req never asserts; next slice QBUS=0 for all 8 pixels; miss_cnt unchanged.
- Ack withheld for 10 cycles past B:
  - that slice QBUS=0 and miss_cnt=1;
  - the stale data is discarded;
  - the pending address is issued on the cycle after the ack;
  - the following slice shows the correct pixels.
- Ack coincident with B, rom_data=0xFF_00_00 -> next slice QBUS=4 for all 8 pixels; miss_cnt=0.
- Reset asserted while rom_req=1:
  - rom_req, QBUS and miss_cnt read 0 at once;
  - an ack arriving during reset or afterwards has no effect.
- 300 consecutive missed slices -> miss_cnt saturates at 255.
